// File: rtl/vga_pkg.sv
// Shared VGA timing constants, image geometry and renderer types for the
// 640x480@60 display path.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  localparam int IMG_W = 256;
  localparam int IMG_H = 256;

  typedef logic [23:0] rgb24_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } render_state_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register used to keep sync and video_on aligned with the
// colour pipeline.
module sync_delay #(
  parameter int               DEPTH   = 3,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_25Mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/pixel_renderer.sv
// Maps the VGA scan position onto a 256x256 RGB332 double-buffered framebuffer.
// Define PIXEL_RENDERER_BORDER_EN to draw a one-pixel ring around the image.
module pixel_renderer
  import vga_pkg::*;
#(
  parameter int     X0           = 192,
  parameter int     Y0           = 112,
  parameter rgb24_t BG_COLOR     = 24'h000000,
  parameter rgb24_t BORDER_COLOR = 24'hFFFFFF
) (
  input  logic        clk_25Mhz,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [16:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        front_buf,
  output logic        frame_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        vga_blank_n
);

  localparam logic [10:0] X_LO  = 11'(X0);
  localparam logic [10:0] X_HI  = 11'(X0 + IMG_W);
  localparam logic [10:0] Y_LO  = 11'(Y0);
  localparam logic [10:0] Y_HI  = 11'(Y0 + IMG_H);
  localparam logic [7:0]  X_OFF = 8'(X0);
  localparam logic [7:0]  Y_OFF = 8'(Y0);

  function automatic rgb24_t expand_rgb332(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
  endfunction

  render_state_t state_q, state_d;
  logic          vs_q, frame_edge;
  logic          front_buf_d, swap_ack_d, frame_start_d;

  // Frame boundary is a v_sync rise; the buffer only flips here so a frame is never split.
  assign frame_edge = v_sync & ~vs_q;

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_FRAME;
      vs_q        <= 1'b0;
      front_buf   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= v_sync;
      front_buf   <= front_buf_d;
      swap_ack    <= swap_ack_d;
      frame_start <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    front_buf_d   = front_buf;
    swap_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      WAIT_FRAME: if (frame_edge) state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_FRAME;
    endcase
    if (frame_edge) begin
      frame_start_d = 1'b1;
      if (swap_req) begin
        front_buf_d = ~front_buf;
        swap_ack_d  = 1'b1;
      end
    end
  end

  logic [10:0] px_w, py_w;
  logic        in_image_c;
  logic [7:0]  dx, dy;

  assign px_w       = {1'b0, pixel_x};
  assign py_w       = {1'b0, pixel_y};
  assign in_image_c = (px_w >= X_LO) && (px_w < X_HI) && (py_w >= Y_LO) && (py_w < Y_HI);
  assign dx         = pixel_x[7:0] - X_OFF;
  assign dy         = pixel_y[7:0] - Y_OFF;

  logic in_image_p0, in_image_p1;

  // Stage 1: framebuffer address (held outside the image) and classification
  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      in_image_p0 <= 1'b0;
    end else begin
      in_image_p0 <= in_image_c;
      if (in_image_c) mem_addr <= {front_buf, dy, dx};
    end
  end

  // Stage 2: RAM read in flight
  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) in_image_p1 <= 1'b0;
    else     in_image_p1 <= in_image_p0;
  end

`ifdef PIXEL_RENDERER_BORDER_EN
  localparam logic [11:0] XB_LO = 12'(X0);
  localparam logic [11:0] XB_HI = 12'(X0 + IMG_W);
  localparam logic [11:0] YB_LO = 12'(Y0);
  localparam logic [11:0] YB_HI = 12'(Y0 + IMG_H);

  logic [11:0] px_b, py_b;
  logic        on_col, on_row, col_span, row_span, ring_c;
  logic        border_p0, border_p1;

  // Compared as x+1 against X0 so the ring still works when X0 or Y0 is zero.
  assign px_b     = {2'b00, pixel_x};
  assign py_b     = {2'b00, pixel_y};
  assign on_col   = (px_b + 12'd1 == XB_LO) || (px_b == XB_HI);
  assign on_row   = (py_b + 12'd1 == YB_LO) || (py_b == YB_HI);
  assign col_span = (px_b + 12'd1 >= XB_LO) && (px_b <= XB_HI);
  assign row_span = (py_b + 12'd1 >= YB_LO) && (py_b <= YB_HI);
  assign ring_c   = (on_col && row_span) || (on_row && col_span);

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      border_p0 <= 1'b0;
      border_p1 <= 1'b0;
    end else begin
      border_p0 <= ring_c;
      border_p1 <= border_p0;
    end
  end
`endif

  logic hs_p1, vs_p1, vld_p1;
  logic hs_p2, vs_p2, vld_p2;

  sync_delay #(.DEPTH(2), .WIDTH(3), .RST_VAL(3'b000)) u_dly_early (
    .clk_25Mhz (clk_25Mhz),
    .rst       (rst),
    .din       ({h_sync, v_sync, video_on}),
    .dout      ({hs_p1, vs_p1, vld_p1})
  );

  sync_delay #(.DEPTH(1), .WIDTH(3), .RST_VAL(3'b000)) u_dly_late (
    .clk_25Mhz (clk_25Mhz),
    .rst       (rst),
    .din       ({hs_p1, vs_p1, vld_p1}),
    .dout      ({hs_p2, vs_p2, vld_p2})
  );

  rgb24_t rgb_p2;

  // Stage 3: colour select
  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      rgb_p2 <= '0;
    end else if (!vld_p1 || state_q == WAIT_FRAME) begin
      rgb_p2 <= '0;
    end else if (in_image_p1) begin
      rgb_p2 <= expand_rgb332(mem_rdata);
`ifdef PIXEL_RENDERER_BORDER_EN
    end else if (border_p1) begin
      rgb_p2 <= BORDER_COLOR;
`endif
    end else begin
      rgb_p2 <= BG_COLOR;
    end
  end

  assign vga_r       = rgb_p2[23:16];
  assign vga_g       = rgb_p2[15:8];
  assign vga_b       = rgb_p2[7:0];
  assign vga_hs_n    = ~hs_p2;
  assign vga_vs_n    = ~vs_p2;
  assign vga_blank_n = vld_p2;

endmodule

// File: tb/tb_pixel_renderer.sv
// Self-checking bench for pixel_renderer with a registered-read framebuffer model
// and a cycle-level reference built from the scan-position rules.
module tb_pixel_renderer;

  localparam int          X0     = 192;
  localparam int          Y0     = 112;
  localparam logic [23:0] BG     = 24'h123456;
  localparam logic [23:0] BORDER = 24'hFFFFFF;

  logic        clk_25Mhz = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic        swap_req = 1'b0;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        swap_ack, front_buf, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs_n, vga_vs_n, vga_blank_n;

  int errors = 0;
  int checks = 0;

  always #20 clk_25Mhz = ~clk_25Mhz;

  pixel_renderer #(.X0(X0), .Y0(Y0), .BG_COLOR(BG), .BORDER_COLOR(BORDER)) dut (
    .clk_25Mhz   (clk_25Mhz),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_buf   (front_buf),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs_n    (vga_hs_n),
    .vga_vs_n    (vga_vs_n),
    .vga_blank_n (vga_blank_n)
  );

  function automatic logic [7:0] ram_val(input logic [16:0] a);
    logic [7:0] v;
    if (a == 17'd0) return 8'hE0;
    v = (a[7:0] * 8'd5) ^ a[15:8] ^ (a[16] ? 8'h5A : 8'h00);
    return v;
  endfunction

  always @(posedge clk_25Mhz) mem_rdata <= ram_val(mem_addr);

  function automatic logic [23:0] expand(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], p[1:0], p[1:0], p[1:0], p[1:0]};
  endfunction

  function automatic bit inside_img(input int x, input int y);
    return (x >= X0) && (x < X0 + 256) && (y >= Y0) && (y < Y0 + 256);
  endfunction

  function automatic bit on_ring(input int x, input int y);
    return !inside_img(x, y) && (x >= X0 - 1) && (x <= X0 + 256) && (y >= Y0 - 1) && (y <= Y0 + 256);
  endfunction

  // Reference state; history index 0 = previous clock, 1 = two clocks back.
  bit          m_run, m_fb, m_vs_prev;
  logic [16:0] m_addr;
  bit          h_von [2];
  bit          h_hs  [2];
  bit          h_vs  [2];
  bit          h_img [2];
  bit          h_brd [2];
  logic [16:0] h_addr [2];
  logic [23:0] e_rgb;
  bit          e_hs_n, e_vs_n, e_blank_n, e_fs, e_ack;

  task automatic model_reset();
    m_run = 0; m_fb = 0; m_vs_prev = 0; m_addr = '0;
    for (int i = 0; i < 2; i++) begin
      h_von[i] = 0; h_hs[i] = 0; h_vs[i] = 0; h_img[i] = 0; h_brd[i] = 0; h_addr[i] = '0;
    end
  endtask

  task automatic cyc(input int x, input int y, input bit von, input bit hs, input bit vs, input bit req);
    @(negedge clk_25Mhz);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; h_sync = hs; v_sync = vs; swap_req = req;
    @(posedge clk_25Mhz);
    if (!h_von[1] || !m_run)  e_rgb = 24'h0;
    else if (h_img[1])        e_rgb = expand(ram_val(h_addr[1]));
`ifdef PIXEL_RENDERER_BORDER_EN
    else if (h_brd[1])        e_rgb = BORDER;
`endif
    else                      e_rgb = BG;
    e_blank_n = h_von[1];
    e_hs_n    = !h_hs[1];
    e_vs_n    = !h_vs[1];
    if (inside_img(x, y)) m_addr = {m_fb, 8'(y - Y0), 8'(x - X0)};
    e_fs  = vs && !m_vs_prev;
    e_ack = e_fs && req;
    if (e_ack) m_fb = !m_fb;
    if (e_fs)  m_run = 1;
    m_vs_prev = vs;
    h_von[1] = h_von[0]; h_hs[1] = h_hs[0]; h_vs[1] = h_vs[0];
    h_img[1] = h_img[0]; h_brd[1] = h_brd[0]; h_addr[1] = h_addr[0];
    h_von[0] = von; h_hs[0] = hs; h_vs[0] = vs;
    h_img[0] = inside_img(x, y); h_brd[0] = on_ring(x, y); h_addr[0] = m_addr;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_25Mhz);
    #1;
    checks++; if (mem_addr !== 17'h0) begin errors++; $display("FAIL reset_mem_addr got %h expected 0", mem_addr); end
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h expected 0", {vga_r, vga_g, vga_b}); end
    checks++; if ({vga_hs_n, vga_vs_n, vga_blank_n} !== 3'b110) begin errors++; $display("FAIL reset_syncs got %b expected 110", {vga_hs_n, vga_vs_n, vga_blank_n}); end
    checks++; if ({swap_ack, frame_start, front_buf} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b expected 000", {swap_ack, frame_start, front_buf}); end
    #5 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_wait_frame();
    int fs_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(X0 + i, Y0 + i, 1, 0, 0, 0);
      checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL wait_black cycle %0d got %h expected 0", i, {vga_r, vga_g, vga_b}); end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(X0 + i, Y0, 1, 0, (i >= 2 && i < 5), 0);
      if (frame_start === 1'b1) fs_cnt++;
    end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d expected 1", fs_cnt); end
    for (int i = 0; i < 4; i++) cyc(X0 + 10, Y0 + 10, 1, 0, 0, 0);
    checks++;
    if ({vga_r, vga_g, vga_b} !== expand(ram_val(17'h00A0A))) begin
      errors++; $display("FAIL run_pixel got %h expected %h", {vga_r, vga_g, vga_b}, expand(ram_val(17'h00A0A)));
    end
  endtask

  task automatic test_known_pixel();
    cyc(192, 112, 1, 0, 0, 0);
    checks++; if (mem_addr !== 17'h00000) begin errors++; $display("FAIL known_addr got %h expected 00000", mem_addr); end
    cyc(100, 50, 0, 0, 0, 0);
    cyc(100, 50, 0, 0, 0, 0);
    checks++; if ({vga_r, vga_g, vga_b} !== 24'hFF0000) begin errors++; $display("FAIL known_rgb got %h expected ff0000", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_background();
    repeat (3) cyc(100, 50, 1, 0, 0, 0);
    checks++; if ({vga_r, vga_g, vga_b} !== BG) begin errors++; $display("FAIL bg_rgb got %h expected %h", {vga_r, vga_g, vga_b}, BG); end
    checks++; if (vga_blank_n !== 1'b1) begin errors++; $display("FAIL bg_blank got %b expected 1", vga_blank_n); end
    repeat (3) cyc(100, 50, 0, 0, 0, 0);
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL off_rgb got %h expected 0", {vga_r, vga_g, vga_b}); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL off_blank got %b expected 0", vga_blank_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(180, 460), $urandom_range(100, 380), $urandom_range(0, 7) != 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));
      checks++; if ({vga_r, vga_g, vga_b} !== e_rgb) begin errors++; $display("FAIL rand_rgb cycle %0d got %h expected %h", i, {vga_r, vga_g, vga_b}, e_rgb); end
      checks++; if ({vga_hs_n, vga_vs_n, vga_blank_n} !== {e_hs_n, e_vs_n, e_blank_n}) begin errors++; $display("FAIL rand_syncs cycle %0d got %b expected %b", i, {vga_hs_n, vga_vs_n, vga_blank_n}, {e_hs_n, e_vs_n, e_blank_n}); end
      checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rand_addr cycle %0d got %h expected %h", i, mem_addr, m_addr); end
      checks++; if ({frame_start, swap_ack, front_buf} !== {e_fs, e_ack, m_fb}) begin errors++; $display("FAIL rand_ctrl cycle %0d got %b expected %b", i, {frame_start, swap_ack, front_buf}, {e_fs, e_ack, m_fb}); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 20; i++) cyc(X0 + i, Y0 + i, 1, 0, 0, 1);
    rst = 1'b1;
    #2;
    checks++; if ({front_buf, vga_blank_n, swap_ack, frame_start} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl got %b expected 0000", {front_buf, vga_blank_n, swap_ack, frame_start}); end
    checks++; if (mem_addr !== 17'h0 || {vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL midrst_data got addr %h rgb %h expected 0", mem_addr, {vga_r, vga_g, vga_b}); end
    #5 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(X0 + i, Y0, 1, 0, 0, 1);
      checks++; if ({vga_r, vga_g, vga_b, swap_ack, front_buf} !== 26'h0) begin errors++; $display("FAIL midrst_black cycle %0d got rgb %h ack %b fb %b expected 0", i, {vga_r, vga_g, vga_b}, swap_ack, front_buf); end
    end
  endtask

  task automatic test_swap();
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if ({frame_start, swap_ack, front_buf} !== 3'b100) begin errors++; $display("FAIL swap_noreq got %b expected 100", {frame_start, swap_ack, front_buf}); end
    cyc(0, 0, 0, 0, 0, 0);
    for (int y = 0; y < 400; y++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(X0 + k, y, 1, 0, 0, y >= 200);
        checks++; if ({swap_ack, front_buf} !== 2'b00) begin errors++; $display("FAIL swap_early row %0d got ack %b fb %b expected 0 0", y, swap_ack, front_buf); end
      end
    end
    cyc(0, 0, 0, 0, 1, 1);
    checks++; if ({frame_start, swap_ack, front_buf} !== 3'b111) begin errors++; $display("FAIL swap_edge got %b expected 111", {frame_start, swap_ack, front_buf}); end
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if ({frame_start, swap_ack} !== 2'b00) begin errors++; $display("FAIL swap_pulse got %b expected 00", {frame_start, swap_ack}); end
    cyc(X0 + 5, Y0 + 5, 1, 0, 0, 1);
    checks++; if (mem_addr !== {1'b1, 8'd5, 8'd5}) begin errors++; $display("FAIL swap_addr got %h expected %h", mem_addr, {1'b1, 8'd5, 8'd5}); end
    for (int i = 0; i < 50; i++) cyc(X0 + i, Y0 + 6, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    checks++; if ({swap_ack, front_buf} !== 2'b10) begin errors++; $display("FAIL swap_held got ack %b fb %b expected 1 0", swap_ack, front_buf); end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if ({frame_start, swap_ack, front_buf} !== 3'b100) begin errors++; $display("FAIL swap_dropped got %b expected 100", {frame_start, swap_ack, front_buf}); end
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hsync();
    int low_cnt = 0;
    int first_low = -1;
    for (int h = 0; h < 806; h++) begin
      cyc((h < 640) ? h : 0, 50, h < 640, (h >= 656 && h <= 751), 0, 0);
      if (vga_hs_n === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = h;
      end
    end
    checks++; if (low_cnt != 96) begin errors++; $display("FAIL hsync_width got %0d expected 96", low_cnt); end
    checks++; if (first_low != 658) begin errors++; $display("FAIL hsync_start got %0d expected 658", first_low); end
  endtask

  task automatic test_border();
    logic [23:0] ring_exp;
`ifdef PIXEL_RENDERER_BORDER_EN
    ring_exp = BORDER;
`else
    ring_exp = BG;
`endif
    repeat (3) cyc(191, 200, 1, 0, 0, 0);
    checks++; if ({vga_r, vga_g, vga_b} !== ring_exp) begin errors++; $display("FAIL border_left got %h expected %h", {vga_r, vga_g, vga_b}, ring_exp); end
    repeat (3) cyc(X0 + 256, Y0 - 1, 1, 0, 0, 0);
    checks++; if ({vga_r, vga_g, vga_b} !== ring_exp) begin errors++; $display("FAIL border_corner got %h expected %h", {vga_r, vga_g, vga_b}, ring_exp); end
    repeat (3) cyc(190, 200, 1, 0, 0, 0);
    checks++; if ({vga_r, vga_g, vga_b} !== BG) begin errors++; $display("FAIL border_outside got %h expected %h", {vga_r, vga_g, vga_b}, BG); end
  endtask

  initial begin
    test_reset();
    test_wait_frame();
    test_known_pixel();
    test_background();
    test_random();
    test_mid_reset();
    test_swap();
    test_hsync();
    test_border();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_renderer.md
PIXEL_RENDERER -- requirements
Module: pixel_renderer

Interface
REQ-001 Parameters SHALL be: X0 default 192, image left column; Y0 default 112, image top row; BG_COLOR default 24'h000000, RGB outside image; BORDER_COLOR default 24'hFFFFFF, border RGB.
REQ-002 Ports SHALL be (name direction width meaning), with one clock; reset is asynchronous and active-high:
- clk_25Mhz  in  1  pixel clock, driven by the VGA timing block's vga_clk
- rst  in  1  async active-high reset
- pixel_x  in  10  current column from the timing block
- pixel_y  in  10  current row from the timing block
- video_on  in  1  active-region flag
- h_sync  in  1  active-high horizontal pulse
- v_sync  in  1  active-high vertical pulse
- mem_addr  out  17  framebuffer byte address {buf, row[7:0], col[7:0]}
- mem_rdata  in  8  RGB332 pixel, valid one clock after mem_addr (registered-read RAM)
- swap_req  in  1  producer requests buffer swap, level held until ack
- swap_ack  out  1  one-cycle swap-done pulse
- front_buf  out  1  buffer currently displayed
- frame_start  out  1  one-cycle pulse per frame boundary
- vga_r, vga_g, vga_b  out  8 each  colour to DAC
- vga_hs_n, vga_vs_n  out  1 each  active-low syncs
- vga_blank_n  out  1  low outside active region

Function
REQ-003 Pipeline latency SHALL be exactly 3 clocks from pixel_x/pixel_y/video_on/h_sync/v_sync to vga_r/g/b, vga_hs_n, vga_vs_n, vga_blank_n.
REQ-004 Stage 1 SHALL register mem_addr = {front_buf, (pixel_y-Y0)[7:0], (pixel_x-X0)[7:0]} and an in_image flag; stage 2 is RAM latency; stage 3 SHALL register colour.
REQ-005 in_image SHALL be true iff X0 <= pixel_x < X0+256 and Y0 <= pixel_y < Y0+256, evaluated in 11-bit unsigned arithmetic without wrap.
REQ-006 Outside in_image, mem_addr SHALL hold its previous value.
REQ-007 RGB332 expansion SHALL be: r={p[7:5],p[7:5],p[7:6]}, g={p[4:2],p[4:2],p[4:3]}, b={p[1:0],p[1:0],p[1:0],p[1:0]}.
REQ-008 Colour priority SHALL be: delayed video_on low or state WAIT_FRAME -> 0; in_image -> expanded pixel; otherwise BG_COLOR.
REQ-009 vga_hs_n/vga_vs_n SHALL be the inverted, 3-clock-delayed h_sync/v_sync; vga_blank_n SHALL be the delayed video_on.
REQ-010 The frame boundary SHALL be the rising edge of v_sync, detected against a registered copy; frame_start SHALL pulse for one clock on the cycle after that edge.
REQ-011 The FSM SHALL have states WAIT_FRAME and RUN: WAIT_FRAME -> RUN on the first frame boundary; RUN is held until reset.
REQ-012 If swap_req is high at a frame boundary, front_buf SHALL toggle and swap_ack SHALL pulse in the same cycle as frame_start; otherwise there is no toggle and no ack.
REQ-013 A swap_req asserted mid-frame SHALL wait for the next boundary; swap_req held high after ack SHALL trigger another swap at the following boundary.
REQ-014 A front_buf change SHALL take effect only for addresses issued after the toggle; the visible frame is never split.

Reset
REQ-015 On rst, all outputs SHALL go immediately to: mem_addr 0, vga_r/g/b 0, vga_hs_n 1, vga_vs_n 1, vga_blank_n 0, swap_ack 0, frame_start 0, front_buf 0.
REQ-016 On rst, state SHALL be WAIT_FRAME and the delay lines SHALL clear to the inactive values (syncs low, video_on low).
REQ-017 Reset mid-frame SHALL discard pending swap state; output SHALL stay black until the next full frame boundary.

Configuration
REQ-018 With PIXEL_RENDERER_BORDER_EN defined, the one-pixel ring just outside the image (x=X0-1 or X0+256 with Y0-1<=y<=Y0+256, and symmetric rows) SHALL display BORDER_COLOR when video_on is high.
REQ-019 Without PIXEL_RENDERER_BORDER_EN, the ring SHALL display BG_COLOR, and no border logic SHALL be synthesised.

Structure
REQ-020 A shared package vga_pkg SHALL hold H/V active and sync constants, IMG_W=256, IMG_H=256, the rgb24_t typedef, and the renderer state enum.
REQ-021 One sub-module, sync_delay (parameterised depth, width, reset value), SHALL implement the sync/video_on delay lines.

Verification
REQ-022 After reset with a full frame driven: output black until the first v_sync rise; frame_start pulses once; then state RUN.
REQ-023 With pixel_x=192, pixel_y=112, video_on=1: mem_addr=17'h00000 one clock later; with mem_rdata=8'hE0, vga_r=8'hFF, vga_g=0, vga_b=0 three clocks after the input.
REQ-024 With pixel_x=100, pixel_y=50, video_on=1: output is BG_COLOR; with video_on=0: output is 0 and vga_blank_n=0.
REQ-025 swap_req raised at pixel_y=200: swap_ack and the front_buf 0->1 toggle occur only at the next v_sync rise; mem_addr[16]=1 from the next frame onward.
REQ-026 h_sync pulse at h_counter 656-751: vga_hs_n is low for exactly 96 clocks, starting 3 clocks later.
REQ-027 With PIXEL_RENDERER_BORDER_EN defined, pixel (191,200) shows 24'hFFFFFF; without it, the same pixel shows BG_COLOR.
